// File: rtl/lightgun_port_pkg.sv
// Shared definitions for the light-gun controller-port stage: FSM state
// encoding, bus widths and the H-counter latch arithmetic.
package lightgun_port_pkg;

  localparam int HCNT_W   = 9;
  localparam int HLATCH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2,
    REARM = 2'd3
  } lp_state_t;

  // The VDP reports H in 2-pixel units, so the LSB is dropped; the trim
  // offset is added with 8-bit wraparound.
  function automatic logic [HLATCH_W-1:0] h_latch_value(
    input logic [HCNT_W-1:0]   hcnt,
    input logic [HLATCH_W-1:0] offset
  );
    return hcnt[HCNT_W-1:1] + offset;
  endfunction

endpackage

// File: rtl/lightgun_port_if.sv
// Signal bundle between the light-gun / VDP side and the controller-port
// stage. master drives the sensor-side levels, slave produces pin levels.
interface lightgun_port_if;
  import lightgun_port_pkg::*;

  logic                CE_PIX;
  logic                GUN_EN;
  logic                TH_INPUT;
  logic                SENSOR;
  logic                TRIGGER;
  logic                VBLANK;
  logic [HCNT_W-1:0]   HCNT;
  logic                TH_OUT;
  logic                TL_OUT;
  logic [HLATCH_W-1:0] HLATCH;
  logic                LATCH_STB;

  modport master (
    output CE_PIX, GUN_EN, TH_INPUT, SENSOR, TRIGGER, VBLANK, HCNT,
    input  TH_OUT, TL_OUT, HLATCH, LATCH_STB
  );

  modport slave (
    input  CE_PIX, GUN_EN, TH_INPUT, SENSOR, TRIGGER, VBLANK, HCNT,
    output TH_OUT, TL_OUT, HLATCH, LATCH_STB
  );

endinterface

// File: rtl/lightgun_trig_debounce.sv
// Frame-based trigger filter. TRIGGER is sampled once per frame (VBLANK
// rise) and TL only flips after DEBOUNCE consecutive differing samples.
// TL is active-low: 0 means the trigger is pressed.
module lightgun_trig_debounce #(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic gun_en,
  input  logic trigger,
  input  logic vblank,
  output logic tl_out
);

  localparam logic [2:0] DEBOUNCE_LAST = DEBOUNCE[2:0];

  logic       vblank_q;
  logic [2:0] cnt_reg;
  logic [2:0] cnt_next;
  logic       tl_reg;
  logic       tl_next;
  logic       vblank_rise;
  logic [2:0] cnt_inc;
  logic       pressed_now;

  assign vblank_rise = vblank & ~vblank_q;
  assign cnt_inc     = cnt_reg + 3'd1;
  assign pressed_now = ~tl_reg;

  // Count consecutive frames whose sample disagrees with the reported state.
  always_comb begin
    cnt_next = cnt_reg;
    tl_next  = tl_reg;
    if (!gun_en) begin
      cnt_next = 3'd0;
      tl_next  = 1'b1;
    end else if (vblank_rise) begin
      if (trigger != pressed_now) begin
        if (cnt_inc == DEBOUNCE_LAST) begin
          tl_next  = ~trigger;
          cnt_next = 3'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end else begin
        cnt_next = 3'd0;
      end
    end
  end

  // Edge register, counter and pin level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vblank_q <= 1'b0;
      cnt_reg  <= 3'd0;
      tl_reg   <= 1'b1;
    end else begin
      vblank_q <= vblank;
      cnt_reg  <= cnt_next;
      tl_reg   <= tl_next;
    end
  end

  assign tl_out = tl_reg;

endmodule

// File: rtl/lightgun_port.sv
// Light-gun controller-port stage: turns SENSOR into an active-low TH pulse
// of HOLD_PIX pixels, latches the H counter on each accepted hit, and
// drives TL from the debounced trigger.
module lightgun_port
  import lightgun_port_pkg::*;
#(
  parameter int unsigned          HOLD_PIX = 64,
  parameter int unsigned          DEBOUNCE = 2,
  parameter logic [HLATCH_W-1:0]  HOFFSET  = 8'd0
) (
  input  logic          CLK,
  input  logic          RESET_N,
  lightgun_port_if.slave bus
);

  localparam int HOLD_CNT_W = $clog2(HOLD_PIX + 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_PIX[HOLD_CNT_W-1:0];

  lp_state_t             state_reg;
  lp_state_t             state_next;
  logic                  sensor_q;
  logic [HOLD_CNT_W-1:0] hold_cnt_reg;
  logic [HOLD_CNT_W-1:0] hold_cnt_next;
  logic [HOLD_CNT_W-1:0] hold_inc;
  logic                  th_reg;
  logic                  th_next;
  logic                  stb_reg;
  logic                  stb_next;
  logic [HLATCH_W-1:0]   hlatch_reg;
  logic [HLATCH_W-1:0]   hlatch_next;
  logic                  sensor_rise;
  logic                  hold_done;

  // Rise detection runs every CLK so a short SENSOR pulse is not missed
  // between pixel enables.
  assign sensor_rise = bus.SENSOR & ~sensor_q;
  assign hold_inc    = hold_cnt_reg + 1'b1;
  assign hold_done   = bus.CE_PIX && (hold_inc == HOLD_LAST);

  // State, edge register and registered pin outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      sensor_q     <= 1'b0;
      hold_cnt_reg <= '0;
      th_reg       <= 1'b1;
      stb_reg      <= 1'b0;
      hlatch_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      sensor_q     <= bus.SENSOR;
      hold_cnt_reg <= hold_cnt_next;
      th_reg       <= th_next;
      stb_reg      <= stb_next;
      hlatch_reg   <= hlatch_next;
    end
  end

  // Next-state: one LATCH cycle per accepted hit, re-arm only after SENSOR
  // has dropped; deselecting the gun always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sensor_rise && bus.TH_INPUT) state_next = LATCH;
      LATCH:   state_next = HOLD;
      HOLD:    if (hold_done) state_next = REARM;
      REARM:   if (!bus.SENSOR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!bus.GUN_EN) begin
      state_next = IDLE;
    end
  end

  // Outputs: latch H and drop TH in LATCH, hold TH low while counting
  // pixels, and keep everything idle while the gun is deselected.
  always_comb begin
    th_next       = 1'b1;
    stb_next      = 1'b0;
    hold_cnt_next = hold_cnt_reg;
    hlatch_next   = hlatch_reg;
    case (state_reg)
      LATCH: begin
        hlatch_next   = h_latch_value(bus.HCNT, HOFFSET);
        stb_next      = 1'b1;
        th_next       = 1'b0;
        hold_cnt_next = '0;
      end
      HOLD: begin
        th_next = 1'b0;
        if (bus.CE_PIX) begin
          hold_cnt_next = hold_inc;
          if (hold_done) begin
            th_next = 1'b1;
          end
        end
      end
      default: begin
        th_next = 1'b1;
      end
    endcase
    if (!bus.GUN_EN) begin
      th_next       = 1'b1;
      stb_next      = 1'b0;
      hold_cnt_next = '0;
      hlatch_next   = hlatch_reg;
    end
  end

  lightgun_trig_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_trig_debounce (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .gun_en  (bus.GUN_EN),
    .trigger (bus.TRIGGER),
    .vblank  (bus.VBLANK),
    .tl_out  (bus.TL_OUT)
  );

  assign bus.TH_OUT    = th_reg;
  assign bus.LATCH_STB = stb_reg;
  assign bus.HLATCH    = hlatch_reg;

endmodule

// File: tb/tb_lightgun_port.sv
// Testbench for lightgun_port. Two instances share the same stimulus:
// u_dut0 with HOFFSET=0 and u_dut1 with HOFFSET=10, so latch arithmetic and
// the offset wrap are checked on every hit.
module tb_lightgun_port;
  import lightgun_port_pkg::*;

  typedef struct {
    logic [8:0] hcnt;
    logic [7:0] h0;
    logic [7:0] h1;
  } hit_vec_t;

  typedef struct {
    logic trig;
    logic tl;
  } deb_vec_t;

  logic CLK = 1'b0;
  logic RESET_N;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 CLK = ~CLK;

  lightgun_port_if bus0 ();
  lightgun_port_if bus1 ();

  assign bus1.CE_PIX   = bus0.CE_PIX;
  assign bus1.GUN_EN   = bus0.GUN_EN;
  assign bus1.TH_INPUT = bus0.TH_INPUT;
  assign bus1.SENSOR   = bus0.SENSOR;
  assign bus1.TRIGGER  = bus0.TRIGGER;
  assign bus1.VBLANK   = bus0.VBLANK;
  assign bus1.HCNT     = bus0.HCNT;

  lightgun_port #(.HOLD_PIX(64), .DEBOUNCE(2), .HOFFSET(8'd0)) u_dut0 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus0.slave)
  );

  lightgun_port #(.HOLD_PIX(64), .DEBOUNCE(2), .HOFFSET(8'd10)) u_dut1 (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus1.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Run pixel enables until TH returns high; report pulses and strobes seen.
  task automatic wait_hold_end(output int n, output int stb_seen);
    n = 0;
    stb_seen = 0;
    bus0.CE_PIX = 1'b1;
    while (bus0.TH_OUT == 1'b0 && n < 200) begin
      tick();
      n++;
      if (bus0.LATCH_STB) stb_seen++;
    end
    bus0.CE_PIX = 1'b0;
  endtask

  task automatic frame(input logic trig);
    bus0.TRIGGER = trig;
    bus0.VBLANK  = 1'b1;
    tick();
    bus0.VBLANK  = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hit_vec_t hits [6];
    deb_vec_t debs [10];
    int n;
    int stb_seen;

    hits[0] = '{9'd200, 8'd100, 8'd110};
    hits[1] = '{9'd500, 8'd250, 8'd4};
    hits[2] = '{9'd511, 8'd255, 8'd9};
    hits[3] = '{9'd1,   8'd0,   8'd10};
    hits[4] = '{9'd3,   8'd1,   8'd11};
    hits[5] = '{9'd490, 8'd245, 8'd255};

    debs[0] = '{1'b1, 1'b1};
    debs[1] = '{1'b0, 1'b1};
    debs[2] = '{1'b1, 1'b1};
    debs[3] = '{1'b1, 1'b0};
    debs[4] = '{1'b1, 1'b0};
    debs[5] = '{1'b0, 1'b0};
    debs[6] = '{1'b1, 1'b0};
    debs[7] = '{1'b0, 1'b0};
    debs[8] = '{1'b0, 1'b1};
    debs[9] = '{1'b0, 1'b1};

    RESET_N       = 1'b0;
    bus0.CE_PIX   = 1'b0;
    bus0.GUN_EN   = 1'b1;
    bus0.TH_INPUT = 1'b1;
    bus0.SENSOR   = 1'b0;
    bus0.TRIGGER  = 1'b0;
    bus0.VBLANK   = 1'b0;
    bus0.HCNT     = 9'd0;
    tick();
    tick();
    check("reset_th",  bus0.TH_OUT, 1);
    check("reset_tl",  bus0.TL_OUT, 1);
    check("reset_hl",  bus0.HLATCH, 0);
    check("reset_stb", bus0.LATCH_STB, 0);
    RESET_N = 1'b1;
    tick();

    // Table-driven hits: latency, latch values, hold length, re-arm.
    for (int i = 0; i < 6; i++) begin
      bus0.HCNT   = hits[i].hcnt;
      bus0.SENSOR = 1'b1;
      tick();
      check($sformatf("hit%0d_lat1_stb", i), bus0.LATCH_STB, 0);
      check($sformatf("hit%0d_lat1_th", i), bus0.TH_OUT, 1);
      tick();
      check($sformatf("hit%0d_stb", i), bus0.LATCH_STB, 1);
      check($sformatf("hit%0d_th", i), bus0.TH_OUT, 0);
      check($sformatf("hit%0d_hl0", i), bus0.HLATCH, int'(hits[i].h0));
      check($sformatf("hit%0d_hl1", i), bus1.HLATCH, int'(hits[i].h1));
      wait_hold_end(n, stb_seen);
      check($sformatf("hit%0d_hold_len", i), n, 64);
      check($sformatf("hit%0d_hold_stb", i), stb_seen, 0);
      tick();
      check($sformatf("hit%0d_rearm_th", i), bus0.TH_OUT, 1);
      check($sformatf("hit%0d_rearm_stb", i), bus0.LATCH_STB, 0);
      bus0.SENSOR = 1'b0;
      tick();
      tick();
    end

    // Re-hit during HOLD is ignored and does not restart the count.
    bus0.HCNT   = 9'd200;
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("rehit_first_hl", bus0.HLATCH, 100);
    n = 0;
    stb_seen = 0;
    bus0.CE_PIX = 1'b1;
    while (bus0.TH_OUT == 1'b0 && n < 200) begin
      tick();
      n++;
      if (bus0.LATCH_STB) stb_seen++;
      if (n == 10) bus0.SENSOR = 1'b0;
      if (n == 12) begin
        bus0.SENSOR = 1'b1;
        bus0.HCNT   = 9'd300;
      end
    end
    bus0.CE_PIX = 1'b0;
    check("rehit_hold_len", n, 64);
    check("rehit_stb", stb_seen, 0);
    check("rehit_hl", bus0.HLATCH, 100);
    stb_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus0.LATCH_STB) stb_seen++;
    end
    check("rehit_held_th", bus0.TH_OUT, 1);
    check("rehit_held_stb", stb_seen, 0);
    bus0.SENSOR = 1'b0;
    tick();
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("rehit_new_stb", bus0.LATCH_STB, 1);
    check("rehit_new_hl", bus0.HLATCH, 150);
    wait_hold_end(n, stb_seen);
    bus0.SENSOR = 1'b0;
    tick();
    tick();

    // TH_INPUT=0 blocks latching.
    bus0.TH_INPUT = 1'b0;
    bus0.HCNT     = 9'd20;
    bus0.SENSOR   = 1'b1;
    stb_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus0.LATCH_STB) stb_seen++;
    end
    check("thin_th", bus0.TH_OUT, 1);
    check("thin_stb", stb_seen, 0);
    check("thin_hl", bus0.HLATCH, 150);
    bus0.SENSOR   = 1'b0;
    bus0.TH_INPUT = 1'b1;
    tick();

    // GUN_EN dropping mid-HOLD releases TH next cycle and returns to IDLE.
    bus0.HCNT   = 9'd40;
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("gun_hit_stb", bus0.LATCH_STB, 1);
    bus0.CE_PIX = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("gun_mid_th", bus0.TH_OUT, 0);
    bus0.GUN_EN = 1'b0;
    tick();
    check("gun_off_th", bus0.TH_OUT, 1);
    check("gun_off_hl", bus0.HLATCH, 20);
    bus0.GUN_EN = 1'b1;
    tick();
    tick();
    check("gun_on_th", bus0.TH_OUT, 1);
    check("gun_on_stb", bus0.LATCH_STB, 0);
    bus0.CE_PIX = 1'b0;
    bus0.SENSOR = 1'b0;
    tick();
    bus0.HCNT   = 9'd60;
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("gun_relatch_stb", bus0.LATCH_STB, 1);
    check("gun_relatch_hl", bus0.HLATCH, 30);
    wait_hold_end(n, stb_seen);
    check("gun_relatch_len", n, 64);
    bus0.SENSOR = 1'b0;
    tick();
    tick();

    // SENSOR rise in the same cycle GUN_EN falls: no latch.
    bus0.HCNT   = 9'd80;
    bus0.SENSOR = 1'b1;
    bus0.GUN_EN = 1'b0;
    stb_seen = 0;
    tick();
    if (bus0.LATCH_STB) stb_seen++;
    bus0.GUN_EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus0.LATCH_STB) stb_seen++;
    end
    check("coinc_stb", stb_seen, 0);
    check("coinc_th", bus0.TH_OUT, 1);
    check("coinc_hl", bus0.HLATCH, 30);
    bus0.SENSOR = 1'b0;
    tick();

    // Table-driven trigger debounce, one frame per entry.
    for (int i = 0; i < 10; i++) begin
      frame(debs[i].trig);
      check($sformatf("deb%0d_tl", i), bus0.TL_OUT, int'(debs[i].tl));
    end

    // TRIGGER changes without a VBLANK rise have no effect.
    bus0.TRIGGER = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("deb_novbl_tl", bus0.TL_OUT, 1);

    // GUN_EN=0 forces TL high and clears a partial count.
    frame(1'b1);
    frame(1'b1);
    check("deb_press_tl", bus0.TL_OUT, 0);
    frame(1'b0);
    check("deb_partial_tl", bus0.TL_OUT, 0);
    bus0.GUN_EN = 1'b0;
    tick();
    check("deb_gunoff_tl", bus0.TL_OUT, 1);
    bus0.GUN_EN = 1'b1;
    tick();
    frame(1'b1);
    check("deb_cleared_tl", bus0.TL_OUT, 1);
    frame(1'b1);
    check("deb_repress_tl", bus0.TL_OUT, 0);

    // Asynchronous reset in the middle of HOLD.
    bus0.HCNT   = 9'd100;
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("areset_pre_hl", bus0.HLATCH, 50);
    bus0.CE_PIX = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("areset_pre_th", bus0.TH_OUT, 0);
    #2;
    RESET_N = 1'b0;
    #1;
    check("areset_th", bus0.TH_OUT, 1);
    check("areset_tl", bus0.TL_OUT, 1);
    check("areset_hl", bus0.HLATCH, 0);
    check("areset_stb", bus0.LATCH_STB, 0);
    bus0.CE_PIX = 1'b0;
    bus0.SENSOR = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    check("areset_after_th", bus0.TH_OUT, 1);
    check("areset_after_tl", bus0.TL_OUT, 1);
    bus0.HCNT   = 9'd222;
    bus0.SENSOR = 1'b1;
    tick();
    tick();
    check("areset_hit_stb", bus0.LATCH_STB, 1);
    check("areset_hit_th", bus0.TH_OUT, 0);
    check("areset_hit_hl0", bus0.HLATCH, 111);
    check("areset_hit_hl1", bus1.HLATCH, 121);
    wait_hold_end(n, stb_seen);
    check("areset_hit_len", n, 64);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lightgun_port.md
Name: lightgun_port

Overview:
- Controller-port stage directly downstream of the light-gun sensor and crosshair logic.
- Converts the gun's SENSOR and TRIGGER levels into SMS controller-port pin levels: TH is light, TL is trigger, both active-low.
- Latches the VDP horizontal counter on each accepted TH falling edge, for the VDP's H-counter read port.
- Sits between the light-gun block and the I/O port / VDP read mux.

Parameters:
- HOLD_PIX, 64, number of CE_PIX pulses that TH stays low after a hit.
- DEBOUNCE, 2, number of consecutive frames TRIGGER must be stable before TL changes (1..7).
- HOFFSET, 8'd0, constant added mod 256 to the latched H value for phaser timing trim.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CE_PIX  in  1  pixel clock enable.
- GUN_EN  in  1  light gun selected on this port; 0 forces the pins idle.
- TH_INPUT  in  1  TH pin configured as input (I/O control register); latching only allowed when 1.
- SENSOR  in  1  light detected (level, from the light-gun block).
- TRIGGER  in  1  trigger pressed (level).
- VBLANK  in  1  VDP vertical blank level.
- HCNT  in  9  VDP horizontal pixel counter.
- TH_OUT  out  1  port TH pin level, 0 = light.
- TL_OUT  out  1  port TL pin level, 0 = trigger pressed.
- HLATCH  out  8  latched H counter value.
- LATCH_STB  out  1  one-CLK pulse when HLATCH is updated.

Behaviour:
- Reset (async, RESET_N=0): TH_OUT=1, TL_OUT=1, HLATCH=8'h00, LATCH_STB=0, FSM=IDLE, hold counter=0, debounce counter=0, sensor edge register=0, vblank edge register=0.
- SENSOR rise detection: compare the registered SENSOR against the current SENSOR in CLK, not gated by CE_PIX.
- FSM states IDLE, LATCH, HOLD, REARM:
  - IDLE: TH_OUT=1. On SENSOR rise with GUN_EN=1 and TH_INPUT=1, go to LATCH.
  - LATCH (exactly 1 CLK): HLATCH <= HCNT[8:1] + HOFFSET (8-bit wrap); LATCH_STB=1; TH_OUT<=0; clear hold counter; go to HOLD. Total latency from the SENSOR rise to the LATCH_STB/TH_OUT change is 2 CLK.
  - HOLD: TH_OUT=0. Increment the hold counter on each CE_PIX. When the count reaches HOLD_PIX, set TH_OUT<=1 and go to REARM. SENSOR rises during HOLD are ignored (no re-latch, no counter restart).
  - REARM: TH_OUT=1. Go to IDLE once SENSOR=0. If SENSOR is already 0, this takes one cycle.
- GUN_EN=0 in any state: next state IDLE, TH_OUT=1, TL_OUT=1. HLATCH holds its value. The debounce counter clears.
- TH_INPUT dropping to 0 during HOLD: the HOLD countdown still completes. Only new latches are blocked.
- SENSOR rise coinciding with GUN_EN falling: GUN_EN wins and no latch occurs.
- Trigger debounce:
  - Sample TRIGGER on the VBLANK rising edge.
  - If the sample differs from the current ~TL_OUT, increment a 3-bit counter; otherwise clear the counter.
  - When the counter reaches DEBOUNCE, TL_OUT <= ~sample and the counter clears.
  - TL_OUT changes only in the CLK cycle following a VBLANK rise.
- HCNT arithmetic: use 9-bit HCNT[8:1] only; bit 0 is dropped. Adding HOFFSET wraps, e.g. 8'hFF + 1 = 8'h00.
- Reset asserted mid-HOLD: TH_OUT returns to 1 immediately (asynchronously).

Decomposition:
- Shared package (e.g. the SMS I/O package): FSM state enum lp_state_t {IDLE, LATCH, HOLD, REARM}, plus the widths of the HCNT and HLATCH buses.
- One natural sub-module: lightgun_trig_debounce (frame-based trigger filter, produces TL_OUT). The FSM and H latch remain in lightgun_port.

Test Plan:
- Basic hit: GUN_EN=1, TH_INPUT=1, HCNT=9'd200, SENSOR 0->1 -> after 2 CLK, LATCH_STB pulses once, HLATCH=8'd100, TH_OUT=0. TH_OUT stays 0 for exactly 64 CE_PIX, then returns to 1.
- Offset wrap: HOFFSET=8'd10, HCNT=9'd500, SENSOR rise -> HLATCH=8'd4 (250+10 mod 256).
- Re-hit masking: second SENSOR rise 10 CE_PIX into HOLD -> no LATCH_STB, HLATCH unchanged. With SENSOR held 1 through HOLD end, TH_OUT=1 and no new latch until SENSOR drops and rises again.
- Gating:
  - TH_INPUT=0 with a SENSOR rise -> TH_OUT stays 1, no LATCH_STB.
  - GUN_EN 1->0 mid-HOLD -> TH_OUT=1 next CLK, FSM in IDLE.
- Trigger debounce with DEBOUNCE=2:
  - TRIGGER=1 for 1 frame, then 0 -> TL_OUT stays 1.
  - TRIGGER=1 for 2 VBLANK rises -> TL_OUT=0 after the second.
  - Release needs 2 frames of TRIGGER=0 before TL_OUT=1.
- Async reset: RESET_N pulsed low mid-HOLD between CLK edges -> TH_OUT=1, TL_OUT=1, HLATCH=0 immediately. After release, a SENSOR rise latches normally.
